rxc: RTL and testbench

Receive-side controller for the alink block: the counterpart of the transmit controller. It watches the receive PHYs, picks one with a frame ready using a round-robin arbiter over the enabled PHYs, and moves that frame word by word into the rx FIFO. When compiled in, it writes a header word before each frame. A per-frame stall timeout aborts transfers from PHYs that stop delivering, and abort events are counted for software.

---
 rtl/rxc.sv | 180 ++++++++++++++++++
 tb/tb_rxc.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxc.sv
// rxc - receive-side controller for the alink block.
// Picks a PHY with a frame ready (round-robin over the enabled PHYs) and moves
// that frame word by word into the rx FIFO. A per-frame stall timeout aborts
// transfers from PHYs that stop delivering; aborts are counted.
// Optional feature macro: ALINK_RX_HDR_EN - when defined, a header word
// {8'hA5, 3'b0, phy_index[4:0], FRM_WORDS[15:0]} is written before each frame.
`ifndef PHY_NUM
`define PHY_NUM 10
`endif

module rxc #(
    parameter int PHY_NUM   = `PHY_NUM,
    parameter int FRM_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_flush,
    input  logic [PHY_NUM-1:0]    reg_mask,
    input  logic [31:0]           reg_rx_tout,
    input  logic [PHY_NUM-1:0]    rx_phy_vld,
    input  logic [32*PHY_NUM-1:0] rx_phy_dat,
    output logic [PHY_NUM-1:0]    rx_phy_ack,
    input  logic                  rx_fifo_full,
    output logic                  rx_fifo_wr,
    output logic [31:0]           rx_fifo_din,
    output logic [PHY_NUM-1:0]    rx_phy_sel,
    output logic [1:0]            cur_state,
    output logic                  rx_frm_done,
    output logic                  rx_err,
    output logic [15:0]           rx_err_cnt,
    output logic                  reg_busy
);

    localparam int          IDX_W   = 5;
    localparam logic [15:0] FRM_W16 = 16'(FRM_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HDR  = 2'b01,
        RECV = 2'b10
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [15:0]        word_cnt;
    logic [31:0]        stall_cnt;

    logic [PHY_NUM-1:0] eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [PHY_NUM-1:0] win_onehot;
    logic               sel_vld;
    logic [31:0]        sel_dat;
    logic [31:0]        hdr_word;
    logic               xfer;
    logic               hdr_wr;
    logic [31:0]        stall_inc;

    // Saturating increment so a very long stall never wraps back to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign eligible = rx_phy_vld & reg_mask;

    // Round-robin search starting one past the last PHY that completed a frame.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        for (int k = 1; k <= PHY_NUM; k++) begin
            for (int i = 0; i < PHY_NUM; i++) begin
                if (!win_found && eligible[i] &&
                    (i == ((int'(rr_ptr) + k >= PHY_NUM) ? int'(rr_ptr) + k - PHY_NUM
                                                          : int'(rr_ptr) + k))) begin
                    win_found     = 1'b1;
                    win_idx       = IDX_W'(i);
                    win_onehot[i] = 1'b1;
                end
            end
        end
    end

    // Valid and data of the PHY currently being served, muxed by the one-hot select.
    always_comb begin
        sel_dat = '0;
        for (int i = 0; i < PHY_NUM; i++) begin
            if (rx_phy_sel[i]) begin
                sel_dat = sel_dat | rx_phy_dat[i*32 +: 32];
            end
        end
    end

    assign sel_vld   = |(rx_phy_vld & rx_phy_sel);
    assign hdr_word  = {8'hA5, 3'b000, sel_idx, FRM_W16};
    assign stall_inc = sat_inc32(stall_cnt);

    // A flush cycle never moves data, so the partial frame stops cleanly.
    assign xfer   = (state == RECV) && sel_vld && !rx_fifo_full && !reg_flush;
    assign hdr_wr = (state == HDR) && !rx_fifo_full && !reg_flush;

    assign rx_phy_ack  = xfer ? rx_phy_sel : '0;
    assign rx_fifo_wr  = xfer || hdr_wr;
    assign rx_fifo_din = (state == HDR) ? hdr_word : sel_dat;
    assign cur_state   = state;
    assign reg_busy    = (state != IDLE);

    // Frame control: selection, header, word transfer, completion, timeout and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rx_phy_sel  <= '0;
            sel_idx     <= '0;
            rr_ptr      <= IDX_W'(PHY_NUM - 1);
            word_cnt    <= '0;
            stall_cnt   <= '0;
            rx_frm_done <= 1'b0;
            rx_err      <= 1'b0;
            rx_err_cnt  <= '0;
        end else begin
            rx_frm_done <= 1'b0;
            rx_err      <= 1'b0;
            if (reg_flush) begin
                state      <= IDLE;
                rx_phy_sel <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (win_found) begin
                            rx_phy_sel <= win_onehot;
                            sel_idx    <= win_idx;
                            word_cnt   <= '0;
                            stall_cnt  <= '0;
`ifdef ALINK_RX_HDR_EN
                            state      <= HDR;
`else
                            state      <= RECV;
`endif
                        end
                    end
                    HDR: begin
                        if (!rx_fifo_full) begin
                            state <= RECV;
                        end
                    end
                    RECV: begin
                        if (xfer) begin
                            stall_cnt <= '0;
                            word_cnt  <= word_cnt + 16'd1;
                            if (word_cnt == FRM_W16 - 16'd1) begin
                                state       <= IDLE;
                                rx_phy_sel  <= '0;
                                rx_frm_done <= 1'b1;
                                rr_ptr      <= sel_idx;
                            end
                        end else begin
                            stall_cnt <= stall_inc;
                            if ((reg_rx_tout != 32'd0) && (stall_inc >= reg_rx_tout)) begin
                                state      <= IDLE;
                                rx_phy_sel <= '0;
                                rx_err     <= 1'b1;
                                rx_err_cnt <= sat_inc16(rx_err_cnt);
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        rx_phy_sel <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rxc.sv
// Directed bench for rxc: PHY_NUM=10, FRM_WORDS=4. A per-cycle vector table
// covers a single frame; hand-written sequences cover arbitration order,
// FIFO-full stall, timeout abort, flush and a long stall with timeout off.
module tb_rxc;

    localparam int PN = 10;
    localparam int FW = 4;
`ifdef ALINK_RX_HDR_EN
    localparam bit HDR_ON = 1'b1;
`else
    localparam bit HDR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            reg_flush;
    logic [PN-1:0]   reg_mask;
    logic [31:0]     reg_rx_tout;
    logic [PN-1:0]   rx_phy_vld;
    logic [32*PN-1:0] rx_phy_dat;
    logic [PN-1:0]   rx_phy_ack;
    logic            rx_fifo_full;
    logic            rx_fifo_wr;
    logic [31:0]     rx_fifo_din;
    logic [PN-1:0]   rx_phy_sel;
    logic [1:0]      cur_state;
    logic            rx_frm_done;
    logic            rx_err;
    logic [15:0]     rx_err_cnt;
    logic            reg_busy;

    rxc #(.PHY_NUM(PN), .FRM_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .reg_flush(reg_flush), .reg_mask(reg_mask),
        .reg_rx_tout(reg_rx_tout), .rx_phy_vld(rx_phy_vld), .rx_phy_dat(rx_phy_dat),
        .rx_phy_ack(rx_phy_ack), .rx_fifo_full(rx_fifo_full), .rx_fifo_wr(rx_fifo_wr),
        .rx_fifo_din(rx_fifo_din), .rx_phy_sel(rx_phy_sel), .cur_state(cur_state),
        .rx_frm_done(rx_frm_done), .rx_err(rx_err), .rx_err_cnt(rx_err_cnt),
        .reg_busy(reg_busy)
    );

    always #5 clk = ~clk;

    // PHY model: word k of PHY i is 32'hD000_i_k; each ack pops one word.
    logic [7:0] phy_cnt [PN];

    always @(posedge clk) begin
        for (int i = 0; i < PN; i++) begin
            if (rst) phy_cnt[i] <= 8'd0;
            else if (rx_phy_ack[i]) phy_cnt[i] <= phy_cnt[i] + 8'd1;
        end
    end

    always_comb begin
        rx_phy_dat = '0;
        for (int i = 0; i < PN; i++) begin
            rx_phy_dat[i*32 +: 32] = {16'hD000, 8'(i), phy_cnt[i]};
        end
    end

    // Monitor: FIFO writes, pulse counts and the order of PHY selections.
    logic [31:0]   wr_log  [$];
    logic [PN-1:0] sel_log [$];
    int            done_seen = 0;
    int            err_seen  = 0;
    logic [PN-1:0] prev_sel  = '0;

    always @(negedge clk) begin
        if (rx_fifo_wr) wr_log.push_back(rx_fifo_din);
        if (rx_frm_done) done_seen = done_seen + 1;
        if (rx_err) err_seen = err_seen + 1;
        if (rx_phy_sel != '0 && prev_sel == '0) sel_log.push_back(rx_phy_sel);
        prev_sel = rx_phy_sel;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        reg_flush    = 1'b0;
        reg_mask     = 10'h3FF;
        reg_rx_tout  = 32'd0;
        rx_phy_vld   = '0;
        rx_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Waits (bounded) until PHY p has popped n words; returns just after the edge.
    task automatic wait_cnt(input int p, input int n, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (int'(phy_cnt[p]) == n) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_sel(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (sel_log.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    typedef struct packed {
        logic [PN-1:0] mask;
        logic [PN-1:0] vld;
        logic          full;
        logic          wr;
        logic [31:0]   din;
        logic [PN-1:0] ack;
        logic [1:0]    st;
        logic [PN-1:0] sel;
        logic          done;
    } vec_t;

    vec_t tv [10];
    int   n_rows;

    initial begin
        int base;
        int dbase;
        int ebase;
        int idx;
        logic [PN-1:0] exp_rr [6];
        logic [PN-1:0] exp_mk [3];

        // ---------------- reset state ----------------
        rst = 1'b1;
        reg_flush = 1'b0; reg_mask = 10'h3FF; reg_rx_tout = 32'd0;
        rx_phy_vld = 10'h3FF; rx_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst state", 32'(cur_state), 32'd0);
        chk("rst sel", 32'(rx_phy_sel), 32'd0);
        chk("rst done", 32'(rx_frm_done), 32'd0);
        chk("rst err", 32'(rx_err), 32'd0);
        chk("rst errcnt", 32'(rx_err_cnt), 32'd0);
        chk("rst wr", 32'(rx_fifo_wr), 32'd0);
        chk("rst ack", 32'(rx_phy_ack), 32'd0);
        chk("rst busy", 32'(reg_busy), 32'd0);

        // ---------------- single frame from PHY 3, per-cycle table ----------------
        tv[0] = '{10'h3F7, 10'h008, 1'b0, 1'b0, 32'h0, 10'h000, 2'd0, 10'h000, 1'b0};
        tv[1] = '{10'h3FF, 10'h008, 1'b0, 1'b0, 32'h0, 10'h000, 2'd0, 10'h000, 1'b0};
        if (HDR_ON) begin
            n_rows = 10;
            tv[2] = '{10'h3FF, 10'h008, 1'b1, 1'b0, 32'h0,        10'h000, 2'd1, 10'h008, 1'b0};
            tv[3] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hA5030004, 10'h000, 2'd1, 10'h008, 1'b0};
            tv[4] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000300, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[5] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000301, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[6] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000302, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[7] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000303, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[8] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 2'd0, 10'h000, 1'b1};
            tv[9] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 2'd0, 10'h000, 1'b0};
        end else begin
            n_rows = 9;
            tv[2] = '{10'h3FF, 10'h008, 1'b1, 1'b0, 32'h0,        10'h000, 2'd2, 10'h008, 1'b0};
            tv[3] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000300, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[4] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000301, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[5] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000302, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[6] = '{10'h3FF, 10'h008, 1'b0, 1'b1, 32'hD0000303, 10'h008, 2'd2, 10'h008, 1'b0};
            tv[7] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 2'd0, 10'h000, 1'b1};
            tv[8] = '{10'h3FF, 10'h000, 1'b0, 1'b0, 32'h0,        10'h000, 2'd0, 10'h000, 1'b0};
        end

        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int r = 0; r < n_rows; r++) begin
            reg_mask     = tv[r].mask;
            rx_phy_vld   = tv[r].vld;
            rx_fifo_full = tv[r].full;
            @(negedge clk);
            chk($sformatf("frame row%0d wr", r), 32'(rx_fifo_wr), 32'(tv[r].wr));
            if (tv[r].wr) chk($sformatf("frame row%0d din", r), rx_fifo_din, tv[r].din);
            chk($sformatf("frame row%0d ack", r), 32'(rx_phy_ack), 32'(tv[r].ack));
            chk($sformatf("frame row%0d state", r), 32'(cur_state), 32'(tv[r].st));
            chk($sformatf("frame row%0d sel", r), 32'(rx_phy_sel), 32'(tv[r].sel));
            chk($sformatf("frame row%0d done", r), 32'(rx_frm_done), 32'(tv[r].done));
            @(posedge clk);
            #1;
        end

        // ---------------- round robin over PHYs 0, 2, 5 ----------------
        exp_rr = '{10'h001, 10'h004, 10'h020, 10'h001, 10'h004, 10'h020};
        do_reset();
        base = sel_log.size();
        rx_phy_vld = 10'h025;
        wait_sel(base + 6, "rr bound");
        rx_phy_vld = '0;
        for (int i = 0; i < 6; i++) begin
            idx = base + i;
            if (idx < sel_log.size()) chk($sformatf("rr order%0d", i), 32'(sel_log[idx]), 32'(exp_rr[i]));
            else chk($sformatf("rr order%0d", i), 32'hFFFFFFFF, 32'(exp_rr[i]));
        end

        // ---------------- round robin with PHY 2 masked out ----------------
        exp_mk = '{10'h001, 10'h020, 10'h001};
        do_reset();
        base = sel_log.size();
        reg_mask = 10'h3FB;
        rx_phy_vld = 10'h025;
        wait_sel(base + 3, "mask bound");
        rx_phy_vld = '0;
        for (int i = 0; i < 3; i++) begin
            idx = base + i;
            if (idx < sel_log.size()) chk($sformatf("mask order%0d", i), 32'(sel_log[idx]), 32'(exp_mk[i]));
            else chk($sformatf("mask order%0d", i), 32'hFFFFFFFF, 32'(exp_mk[i]));
        end

        // ---------------- FIFO full for 3 cycles mid-frame ----------------
        do_reset();
        reg_rx_tout = 32'd10;
        base  = wr_log.size();
        dbase = done_seen;
        ebase = err_seen;
        rx_phy_vld = 10'h010;
        wait_cnt(4, 2, "full pre bound");
        rx_fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("full wr c%0d", c), 32'(rx_fifo_wr), 32'd0);
            chk($sformatf("full ack c%0d", c), 32'(rx_phy_ack), 32'd0);
            @(posedge clk);
            #1;
        end
        rx_fifo_full = 1'b0;
        wait_cnt(4, 4, "full post bound");
        rx_phy_vld = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("full done", 32'(done_seen - dbase), 32'd1);
        chk("full err", 32'(err_seen - ebase), 32'd0);
        chk("full errcnt", 32'(rx_err_cnt), 32'd0);
        chk("full nwr", 32'(wr_log.size() - base), HDR_ON ? 32'd5 : 32'd4);
        idx = base;
        if (HDR_ON && idx < wr_log.size()) begin
            chk("full hdr", wr_log[idx], 32'hA5040004);
            idx++;
        end
        for (int w = 0; w < 4; w++) begin
            if (idx + w < wr_log.size())
                chk($sformatf("full word%0d", w), wr_log[idx + w], 32'hD0000400 + 32'(w));
        end

        // ---------------- timeout abort on PHY 1 ----------------
        do_reset();
        reg_rx_tout = 32'd5;
        rx_phy_vld = 10'h002;
        wait_cnt(1, 2, "tout pre bound");
        rx_phy_vld = '0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("tout state c%0d", c), 32'(cur_state), 32'd2);
            chk($sformatf("tout err c%0d", c), 32'(rx_err), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tout abort state", 32'(cur_state), 32'd0);
        chk("tout abort err", 32'(rx_err), 32'd1);
        chk("tout abort errcnt", 32'(rx_err_cnt), 32'd1);
        chk("tout abort sel", 32'(rx_phy_sel), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tout err one pulse", 32'(rx_err), 32'd0);
        @(posedge clk);
        #1;
        rx_phy_vld = 10'h006;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("tout next sel", 32'(rx_phy_sel), 32'h002);

        // ---------------- flush in RECV after word 1 ----------------
        do_reset();
        dbase = done_seen;
        ebase = err_seen;
        rx_phy_vld = 10'h040;
        wait_cnt(6, 1, "flush pre bound");
        base = wr_log.size();
        reg_flush = 1'b1;
        @(negedge clk);
        chk("flush wr", 32'(rx_fifo_wr), 32'd0);
        chk("flush ack", 32'(rx_phy_ack), 32'd0);
        @(posedge clk);
        #1;
        reg_flush = 1'b0;
        rx_phy_vld = '0;
        @(negedge clk);
        chk("flush state", 32'(cur_state), 32'd0);
        chk("flush sel", 32'(rx_phy_sel), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("flush nwr", 32'(wr_log.size() - base), 32'd0);
        chk("flush done", 32'(done_seen - dbase), 32'd0);
        chk("flush err", 32'(err_seen - ebase), 32'd0);
        chk("flush popped", 32'(phy_cnt[6]), 32'd1);

        // ---------------- long stall with timeout disabled ----------------
        do_reset();
        dbase = done_seen;
        ebase = err_seen;
        rx_phy_vld = 10'h080;
        wait_cnt(7, 2, "stall pre bound");
        rx_phy_vld = '0;
        repeat (1000) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall state", 32'(cur_state), 32'd2);
        chk("stall busy", 32'(reg_busy), 32'd1);
        chk("stall err", 32'(err_seen - ebase), 32'd0);
        @(posedge clk);
        #1;
        rx_phy_vld = 10'h080;
        wait_cnt(7, 4, "stall post bound");
        rx_phy_vld = '0;
        @(negedge clk);
        chk("stall end state", 32'(cur_state), 32'd0);
        @(posedge clk);
        #1;
        chk("stall done", 32'(done_seen - dbase), 32'd1);
        chk("stall errcnt", 32'(rx_err_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
